// File: rtl/spi_mem_port.sv
// spi_mem_port: serial programming and readback port for N memory banks.
// Frames on cs_n/mosi (sampled on posedge clk), MSB first:
//   cmd(1=write) | bank[BANK_W] | addr[ADDR_W] | write: data[DATA_W]
//                                              | read : turnaround, DATA_W miso slots
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   cs_n, mosi, miso  serial pins (miso is the only unregistered output)
//   lock_in           core executing; write commits are refused
//   mem_rdata_in      per-bank read data, bank b at [b*DATA_W +: DATA_W]
//   mem_addr_out      address to all banks, held until the next header completes
//   mem_wdata_out     write data to all banks
//   mem_wen_out       one-hot, single-cycle write strobe
//   busy_out          frame in progress
//   frame_done_out    one-cycle pulse on successful frame completion
//   err_out           sticky error (abort, locked write, bad bank), cleared by rst
module spi_mem_port #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned BANK_W    = 1,
    parameter int unsigned NUM_BANKS = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cs_n,
    input  logic                          mosi,
    output logic                          miso,
    input  logic                          lock_in,
    input  logic [NUM_BANKS*DATA_W-1:0]   mem_rdata_in,
    output logic [ADDR_W-1:0]             mem_addr_out,
    output logic [DATA_W-1:0]             mem_wdata_out,
    output logic [NUM_BANKS-1:0]          mem_wen_out,
    output logic                          busy_out,
    output logic                          frame_done_out,
    output logic                          err_out
);

    localparam int unsigned HDR_W = 1 + BANK_W + ADDR_W;
    localparam int unsigned CNT_W = $clog2(HDR_W + DATA_W + 1);

    typedef enum logic [2:0] {IDLE, HDR, WDATA, TURN, RDATA, DRAIN} state_t;

    state_t                 r_state, w_state_next;
    logic                   r_cs_prev;
    logic [CNT_W-1:0]       r_cnt, w_cnt_next;
    logic [HDR_W-2:0]       r_hdr, w_hdr_next;
    logic [DATA_W-2:0]      r_wshift, w_wshift_next;
    logic [DATA_W-1:0]      r_out, w_out_next;
    logic [BANK_W-1:0]      r_bank, w_bank_next;
    logic [ADDR_W-1:0]      r_addr, w_addr_next;
    logic [DATA_W-1:0]      r_wdata, w_wdata_next;
    logic [NUM_BANKS-1:0]   r_wen, w_wen_next;
    logic                   r_done, w_done_next;
    logic                   r_err, w_err_next;
    logic                   r_busy;

    logic [HDR_W-1:0]       w_hdr_full;
    logic [DATA_W-1:0]      w_word;
    logic [NUM_BANKS-1:0]   w_bank_onehot;
    logic [DATA_W-1:0]      w_bank_rdata;
    logic                   w_bank_valid;
    logic                   w_in_frame;

    assign w_hdr_full = {r_hdr, mosi};
    assign w_word     = {r_wshift, mosi};
    assign w_in_frame = (r_state == HDR) || (r_state == WDATA) ||
                        (r_state == TURN) || (r_state == RDATA);

    // Bank decode; an unimplemented bank yields an all-zero strobe and read word.
    always_comb begin
        w_bank_onehot = '0;
        w_bank_rdata  = '0;
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
            if (r_bank == BANK_W'(b)) begin
                w_bank_onehot[b] = 1'b1;
                w_bank_rdata     = mem_rdata_in[b*DATA_W +: DATA_W];
            end
        end
    end
    assign w_bank_valid = |w_bank_onehot;

    // Next-state and next-output logic.
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_hdr_next    = r_hdr;
        w_wshift_next = r_wshift;
        w_out_next    = r_out;
        w_bank_next   = r_bank;
        w_addr_next   = r_addr;
        w_wdata_next  = r_wdata;
        w_wen_next    = '0;
        w_done_next   = 1'b0;
        w_err_next    = r_err;

        if (cs_n && w_in_frame) begin
            // Master deselected before the frame finished.
            w_state_next = IDLE;
            w_out_next   = '0;
            w_err_next   = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    // Start only on an observed high-to-low transition of cs_n.
                    if (!cs_n && r_cs_prev) begin
                        w_hdr_next   = (HDR_W-1)'(mosi);
                        w_cnt_next   = CNT_W'(1);
                        w_state_next = HDR;
                    end
                end
                HDR: begin
                    w_hdr_next = w_hdr_full[HDR_W-2:0];
                    w_cnt_next = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(HDR_W - 1)) begin
                        w_bank_next  = w_hdr_full[HDR_W-2 -: BANK_W];
                        w_addr_next  = w_hdr_full[ADDR_W-1:0];
                        w_cnt_next   = '0;
                        w_state_next = w_hdr_full[HDR_W-1] ? WDATA : TURN;
                    end
                end
                WDATA: begin
                    w_wshift_next = w_word[DATA_W-2:0];
                    w_cnt_next    = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(DATA_W - 1)) begin
                        w_state_next = DRAIN;
                        if (w_bank_valid && !lock_in) begin
                            w_wdata_next = w_word;
                            w_wen_next   = w_bank_onehot;
                            w_done_next  = 1'b1;
                        end else begin
                            w_err_next = 1'b1;
                        end
                    end
                end
                TURN: begin
                    w_out_next   = w_bank_valid ? w_bank_rdata : '0;
                    w_err_next   = r_err | ~w_bank_valid;
                    w_cnt_next   = '0;
                    w_state_next = RDATA;
                end
                RDATA: begin
                    // Last slot is sampled by the master at this edge; no shift needed.
                    if (r_cnt == CNT_W'(DATA_W - 1)) begin
                        w_out_next   = '0;
                        w_done_next  = w_bank_valid;
                        w_state_next = DRAIN;
                    end else begin
                        w_out_next = {r_out[DATA_W-2:0], 1'b0};
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (cs_n) begin
                        w_state_next = IDLE;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cs_prev <= 1'b0;
            r_cnt     <= '0;
            r_hdr     <= '0;
            r_wshift  <= '0;
            r_out     <= '0;
            r_bank    <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wen     <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cs_prev <= cs_n;
            r_cnt     <= w_cnt_next;
            r_hdr     <= w_hdr_next;
            r_wshift  <= w_wshift_next;
            r_out     <= w_out_next;
            r_bank    <= w_bank_next;
            r_addr    <= w_addr_next;
            r_wdata   <= w_wdata_next;
            r_wen     <= w_wen_next;
            r_done    <= w_done_next;
            r_err     <= w_err_next;
            r_busy    <= (w_state_next != IDLE);
        end
    end

    assign miso           = ((r_state == TURN) || (r_state == RDATA)) ? r_out[DATA_W-1] : 1'b0;
    assign mem_addr_out   = r_addr;
    assign mem_wdata_out  = r_wdata;
    assign mem_wen_out    = r_wen;
    assign busy_out       = r_busy;
    assign frame_done_out = r_done;
    assign err_out        = r_err;

endmodule

// File: tb/tb_spi_mem_port.sv
// Testbench for spi_mem_port: table of write/read frames on a 2-bank instance,
// hand sequences for abort, over-long frame and mid-frame reset, and a 3-bank
// instance (BANK_W=2) for the unimplemented-bank cases.
module tb_spi_mem_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        lock;

    // 2-bank instance
    logic        cs_n, mosi, miso;
    logic [15:0] rdata;
    logic [3:0]  addr_o;
    logic [7:0]  wdata_o;
    logic [1:0]  wen_o;
    logic        busy_o, done_o, err_o;

    // 3-bank instance
    logic        cs_n3, mosi3, miso3;
    logic [23:0] rdata3;
    logic [3:0]  addr3_o;
    logic [7:0]  wdata3_o;
    logic [2:0]  wen3_o;
    logic        busy3_o, done3_o, err3_o;

    int checks   = 0;
    int failures = 0;

    int          wen_cyc = 0, done_cyc = 0, busy_cyc = 0;
    logic [1:0]  last_wen = '0;
    logic [7:0]  last_wdata = '0;
    int          wen3_cyc = 0, done3_cyc = 0;
    logic [2:0]  last_wen3 = '0;

    always #5 clk = ~clk;

    spi_mem_port dut (
        .clk(clk), .rst(rst), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .lock_in(lock), .mem_rdata_in(rdata), .mem_addr_out(addr_o),
        .mem_wdata_out(wdata_o), .mem_wen_out(wen_o), .busy_out(busy_o),
        .frame_done_out(done_o), .err_out(err_o)
    );

    spi_mem_port #(.DATA_W(8), .ADDR_W(4), .BANK_W(2), .NUM_BANKS(3)) dut3 (
        .clk(clk), .rst(rst), .cs_n(cs_n3), .mosi(mosi3), .miso(miso3),
        .lock_in(lock), .mem_rdata_in(rdata3), .mem_addr_out(addr3_o),
        .mem_wdata_out(wdata3_o), .mem_wen_out(wen3_o), .busy_out(busy3_o),
        .frame_done_out(done3_o), .err_out(err3_o)
    );

    // Count strobe/done/busy cycles, sampled mid-cycle.
    always @(negedge clk) begin
        if (wen_o != '0) begin
            wen_cyc    = wen_cyc + 1;
            last_wen   = wen_o;
            last_wdata = wdata_o;
        end
        if (done_o) done_cyc = done_cyc + 1;
        if (busy_o) busy_cyc = busy_cyc + 1;
        if (wen3_o != '0) begin
            wen3_cyc  = wen3_cyc + 1;
            last_wen3 = wen3_o;
        end
        if (done3_o) done3_cyc = done3_cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic set_pins(input bit sel, input logic cs, input logic m);
        if (sel) begin
            cs_n3 = cs;
            mosi3 = m;
        end else begin
            cs_n = cs;
            mosi = m;
        end
    endtask

    // One complete frame: cs_n high for a cycle, bits on edges 0.., then cs_n high.
    task automatic run_frame(input bit sel, input logic wr, input int bank, input int addr,
                             input logic [7:0] data, input int extra, output logic [7:0] rbits);
        int   bw, h, total;
        logic b;
        bw    = sel ? 2 : 1;
        h     = 1 + bw + 4;
        total = h + (wr ? 8 : 9) + extra;
        rbits = '0;
        @(negedge clk);
        set_pins(sel, 1'b1, 1'b0);
        for (int n = 0; n < total; n++) begin
            @(negedge clk);
            if (!wr && n >= h + 1 && n <= h + 8)
                rbits[7 - (n - h - 1)] = sel ? miso3 : miso;
            if (n == 0)                   b = wr;
            else if (n < 1 + bw)          b = 1'((bank >> (bw - n)) & 1);
            else if (n < h)               b = 1'((addr >> (h - 1 - n)) & 1);
            else if (wr && n < h + 8)     b = data[7 - (n - h)];
            else                          b = 1'(n & 1);
            set_pins(sel, 1'b0, b);
        end
        @(negedge clk);
        set_pins(sel, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic        wr;
        int          bank;
        int          addr;
        logic [7:0]  wdata;
        logic [15:0] rdata;
        logic        lock;
        int          exp_strobes;
        logic [1:0]  exp_wen;
        logic [7:0]  exp_wdata;
        logic [7:0]  exp_miso;
        int          exp_done;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [7:0] rb;
        int s_w, s_d, s_b;
        logic [7:0] abort_bits;

        vecs[0] = '{1'b1, 1, 4'h3, 8'hA5, 16'h0000, 1'b0, 1, 2'b10, 8'hA5, 8'h00, 1, 1'b0};
        vecs[1] = '{1'b0, 0, 4'h5, 8'h00, 16'h003C, 1'b0, 0, 2'b00, 8'h00, 8'h3C, 1, 1'b0};
        vecs[2] = '{1'b1, 0, 4'hF, 8'h5A, 16'h0000, 1'b0, 1, 2'b01, 8'h5A, 8'h00, 1, 1'b0};
        vecs[3] = '{1'b0, 1, 4'h0, 8'h00, 16'h8100, 1'b0, 0, 2'b00, 8'h00, 8'h81, 1, 1'b0};
        vecs[4] = '{1'b1, 0, 4'h1, 8'hFF, 16'h0000, 1'b1, 0, 2'b00, 8'h00, 8'h00, 0, 1'b1};
        vecs[5] = '{1'b1, 1, 4'h7, 8'h3C, 16'h0000, 1'b0, 1, 2'b10, 8'h3C, 8'h00, 1, 1'b1};
        vecs[6] = '{1'b0, 1, 4'h2, 8'h00, 16'hC399, 1'b1, 0, 2'b00, 8'h00, 8'hC3, 1, 1'b1};

        rst = 1'b1; lock = 1'b0;
        cs_n = 1'b1; mosi = 1'b0; rdata = '0;
        cs_n3 = 1'b1; mosi3 = 1'b0; rdata3 = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy",  32'(busy_o),  32'h0);
        chk("reset_err",   32'(err_o),   32'h0);
        chk("reset_wen",   32'(wen_o),   32'h0);
        chk("reset_done",  32'(done_o),  32'h0);
        chk("reset_addr",  32'(addr_o),  32'h0);
        chk("reset_wdata", 32'(wdata_o), 32'h0);
        chk("reset_miso",  32'(miso),    32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Table of complete frames on the 2-bank instance.
        for (int i = 0; i < 7; i++) begin
            lock  = vecs[i].lock;
            rdata = vecs[i].rdata;
            s_w   = wen_cyc;
            s_d   = done_cyc;
            run_frame(1'b0, vecs[i].wr, vecs[i].bank, vecs[i].addr, vecs[i].wdata, 0, rb);
            chk($sformatf("v%0d_strobes", i), 32'(wen_cyc - s_w), 32'(vecs[i].exp_strobes));
            chk($sformatf("v%0d_done", i),    32'(done_cyc - s_d), 32'(vecs[i].exp_done));
            chk($sformatf("v%0d_err", i),     32'(err_o), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_addr", i),    32'(addr_o), 32'(vecs[i].addr));
            if (vecs[i].exp_strobes == 1) begin
                chk($sformatf("v%0d_wen", i),   32'(last_wen), 32'(vecs[i].exp_wen));
                chk($sformatf("v%0d_wdata", i), 32'(last_wdata), 32'(vecs[i].exp_wdata));
            end
            if (!vecs[i].wr)
                chk($sformatf("v%0d_miso", i), 32'(rb), 32'(vecs[i].exp_miso));
            lock = 1'b0;
        end
        chk("idle_miso", 32'(miso), 32'h0);

        // Sticky error clears only on reset.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_clears_err", 32'(err_o), 32'h0);

        // Abort: cs_n raised after 9 bits of a write.
        abort_bits = 8'b1000_1000;
        s_w = wen_cyc;
        s_d = done_cyc;
        @(negedge clk);
        cs_n = 1'b1;
        for (int n = 0; n < 9; n++) begin
            @(negedge clk);
            cs_n = 1'b0;
            mosi = (n < 8) ? abort_bits[7 - n] : 1'b1;
        end
        @(negedge clk);
        chk("abort_busy_before", 32'(busy_o), 32'h1);
        cs_n = 1'b1;
        @(negedge clk);
        chk("abort_busy_fell", 32'(busy_o), 32'h0);
        chk("abort_err",       32'(err_o),  32'h1);
        chk("abort_strobes",   32'(wen_cyc - s_w), 32'h0);
        chk("abort_done",      32'(done_cyc - s_d), 32'h0);

        // Write straight after the abort.
        s_w = wen_cyc;
        s_d = done_cyc;
        run_frame(1'b0, 1'b1, 0, 4'h2, 8'h11, 0, rb);
        chk("post_abort_strobes", 32'(wen_cyc - s_w), 32'h1);
        chk("post_abort_wen",     32'(last_wen), 32'h1);
        chk("post_abort_wdata",   32'(last_wdata), 32'h11);
        chk("post_abort_addr",    32'(addr_o), 32'h2);
        chk("post_abort_done",    32'(done_cyc - s_d), 32'h1);

        // 20 bits in one write frame: one strobe only.
        s_w = wen_cyc;
        run_frame(1'b0, 1'b1, 1, 4'hB, 8'h69, 6, rb);
        chk("long_frame_strobes", 32'(wen_cyc - s_w), 32'h1);
        chk("long_frame_wdata",   32'(last_wdata), 32'h69);

        // Reset at edge 8 of a write with cs_n held low afterwards.
        s_w = wen_cyc;
        s_d = done_cyc;
        @(negedge clk);
        cs_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            cs_n = 1'b0;
            mosi = 1'(n < 2 || n == 5);
        end
        @(negedge clk);
        rst = 1'b1;
        mosi = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy_o), 32'h0);
        chk("midrst_wen",  32'(wen_o),  32'h0);
        chk("midrst_err",  32'(err_o),  32'h0);
        s_b = busy_cyc;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            cs_n = 1'b0;
            mosi = 1'(n % 3 != 0);
        end
        @(negedge clk);
        chk("midrst_no_start",   32'(busy_cyc - s_b), 32'h0);
        chk("midrst_no_strobe",  32'(wen_cyc - s_w),  32'h0);
        chk("midrst_no_done",    32'(done_cyc - s_d), 32'h0);
        s_w = wen_cyc;
        run_frame(1'b0, 1'b1, 1, 4'h9, 8'hC7, 0, rb);
        chk("after_toggle_strobes", 32'(wen_cyc - s_w), 32'h1);
        chk("after_toggle_wdata",   32'(last_wdata), 32'hC7);

        // 3-bank instance: bank 2 valid, bank 3 unimplemented.
        rdata3 = 24'hA5FFFF;
        s_w = wen3_cyc;
        s_d = done3_cyc;
        run_frame(1'b1, 1'b1, 2, 4'h4, 8'h5E, 0, rb);
        chk("b3_valid_strobes", 32'(wen3_cyc - s_w), 32'h1);
        chk("b3_valid_wen",     32'(last_wen3), 32'h4);
        chk("b3_valid_wdata",   32'(wdata3_o), 32'h5E);
        chk("b3_valid_err",     32'(err3_o), 32'h0);
        run_frame(1'b1, 1'b0, 2, 4'h1, 8'h00, 0, rb);
        chk("b3_read_bank2", 32'(rb), 32'hA5);
        s_w = wen3_cyc;
        s_d = done3_cyc;
        run_frame(1'b1, 1'b1, 3, 4'h1, 8'h77, 0, rb);
        chk("b3_bad_write_strobes", 32'(wen3_cyc - s_w), 32'h0);
        chk("b3_bad_write_done",    32'(done3_cyc - s_d), 32'h0);
        chk("b3_bad_write_err",     32'(err3_o), 32'h1);
        s_d = done3_cyc;
        run_frame(1'b1, 1'b0, 3, 4'h6, 8'h00, 0, rb);
        chk("b3_bad_read_miso", 32'(rb), 32'h0);
        chk("b3_bad_read_done", 32'(done3_cyc - s_d), 32'h0);
        chk("b3_bad_read_err",  32'(err3_o), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
